// File: rtl/result_display_if.sv
// Handshake between the add stage and the result display: value/load in, busy/done back.
interface result_display_if;
    logic [7:0] value;
    logic       load;
    logic       busy;
    logic       done;

    modport master (output value, output load, input busy, input done);
    modport slave  (input value, input load, output busy, output done);
endinterface

// File: rtl/result_display.sv
// Converts an 8-bit result to BCD by double-dabble and scans it onto a
// 4-digit multiplexed seven-segment display with leading-zero blanking.
module result_display #(
    parameter int REFRESH_DIV = 50000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    result_display_if.slave      bus,
    output logic [3:0]           an,
    output logic [6:0]           seg
);
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [3:0] BLANK = 4'hF;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t      state, state_nxt;
    logic [7:0]  bin;
    logic [11:0] bcd, bcd_adj;
    logic [2:0]  bitcnt;
    logic [3:0]  hund, tens, ones;
    logic        done_q;

    logic [CW-1:0] cnt;
    logic [1:0]    dig, dig_nxt;
    logic [3:0]    dig_val;
    logic [6:0]    code;
    logic [3:0]    an_hi;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'h3F;
            4'd1:    seg_code = 7'h06;
            4'd2:    seg_code = 7'h5B;
            4'd3:    seg_code = 7'h4F;
            4'd4:    seg_code = 7'h66;
            4'd5:    seg_code = 7'h6D;
            4'd6:    seg_code = 7'h7D;
            4'd7:    seg_code = 7'h07;
            4'd8:    seg_code = 7'h7F;
            4'd9:    seg_code = 7'h6F;
            default: seg_code = 7'h00;
        endcase
    endfunction

    // ---------------- conversion FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.load) state_nxt = CONV;
            CONV: if (bitcnt == 3'd7) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // add-3 correction applied before each shift
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5)
                bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin    <= '0;
            bcd    <= '0;
            bitcnt <= '0;
            hund   <= '0;
            tens   <= '0;
            ones   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state == DONE);
            case (state)
                IDLE: if (bus.load) begin
                    bin    <= bus.value;
                    bcd    <= '0;
                    bitcnt <= '0;
                end
                CONV: begin
                    bcd    <= {bcd_adj[10:0], bin[7]};
                    bin    <= {bin[6:0], 1'b0};
                    bitcnt <= bitcnt + 3'd1;
                end
                DONE: begin
                    hund <= bcd[11:8];
                    tens <= bcd[7:4];
                    ones <= bcd[3:0];
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;

    // ---------------- refresh scan ----------------
    assign dig_nxt = (cnt == CNT_LAST) ? dig + 2'd1 : dig;

    always_comb begin
        dig_val = BLANK;
        case (dig_nxt)
            2'd0: dig_val = ones;
            2'd1: dig_val = (hund == 4'd0 && tens == 4'd0) ? BLANK : tens;
            2'd2: dig_val = (hund == 4'd0) ? BLANK : hund;
            default: dig_val = BLANK;
        endcase
        code  = seg_code(dig_val);
        an_hi = 4'b0001 << dig_nxt;
    end

    // an/seg come from the upcoming digit index so both flip on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            dig <= '0;
            an  <= (ACTIVE_LOW != 0) ? 4'b1110 : 4'b0001;
            seg <= (ACTIVE_LOW != 0) ? ~7'h3F : 7'h3F;
        end else begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
            dig <= dig_nxt;
            an  <= (ACTIVE_LOW != 0) ? ~an_hi : an_hi;
            seg <= (ACTIVE_LOW != 0) ? ~code : code;
        end
    end
endmodule

// File: doc/result_display.md
RESULT_DISPLAY -- requirements
Module: result_display

Interface
REQ-001 The block SHALL provide parameter REFRESH_DIV, default 50000, giving the number of clk cycles each digit is driven.
REQ-002 The block SHALL provide parameter ACTIVE_LOW, default 1; 1 means an and seg are driven active-low, 0 means active-high.
REQ-003 The block SHALL provide port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL provide port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL provide port value, input, 8 bits: unsigned result from the add stage, range 0..255.
REQ-006 The block SHALL provide port load, input, 1 bit: request to convert and display value.
REQ-007 The block SHALL provide port busy, output, 1 bit: high while a conversion is in progress.
REQ-008 The block SHALL provide port done, output, 1 bit: one-cycle pulse when the new digits reach the display registers.
REQ-009 The block SHALL provide port an, output, 4 bits: digit enables, with an[0] as the rightmost digit.
REQ-010 The block SHALL provide port seg, output, 7 bits: segments with seg[0]=a through seg[6]=g.

Function
REQ-011 The FSM SHALL have three states: IDLE, CONV and DONE.
REQ-012 In IDLE with load=1, the block SHALL capture value into a shift register, clear the 12-bit BCD accumulator, clear the bit counter and enter CONV.
REQ-013 In IDLE with load=0, the block SHALL hold all state.
REQ-014 CONV SHALL perform one double-dabble step per cycle: add 3 to every BCD nibble >=5, then shift {bcd,bin} left by one; this SHALL run for exactly 8 cycles, then enter DONE.
REQ-015 In DONE, the block SHALL copy the hundreds, tens and ones nibbles into the display registers, assert done for that cycle and return to IDLE.
REQ-016 Latency SHALL be fixed: with load sampled at edge N, the display registers update and done=1 during the cycle after edge N+9.
REQ-017 busy SHALL be 1 in CONV and DONE and 0 in IDLE.
REQ-018 load asserted while busy=1 SHALL be ignored; value is not re-sampled, and the ongoing conversion completes unchanged.
REQ-019 load held high SHALL start a new conversion on the first IDLE cycle after DONE, giving back-to-back conversions every 10 cycles.
REQ-020 The display registers SHALL hold the previous result until DONE, so the display never shows a partial conversion.
REQ-021 Digit mapping SHALL be: digit0=ones, digit1=tens, digit2=hundreds, digit3=always blank.
REQ-022 Leading-zero blanking: hundreds SHALL be blank if 0; tens SHALL be blank if both hundreds and tens are 0; ones SHALL always be shown.
REQ-023 The refresh counter SHALL count 0..REFRESH_DIV-1; on wrap, the digit index SHALL advance 0->1->2->3->0.
REQ-024 Exactly one an bit SHALL be active at any time, matching the digit index.
REQ-025 Active-high segment codes (g..a) SHALL be: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, blank=00.
REQ-026 When ACTIVE_LOW=1, both an and seg SHALL be the bitwise inverse of the active-high values.
REQ-027 an and seg SHALL be registered outputs and SHALL be glitch-free across digit changes.
REQ-028 Refresh scanning SHALL run continuously and SHALL be independent of the conversion FSM.

Reset
REQ-029 When rst=1 at a clock edge, the FSM SHALL go to IDLE, and busy and done SHALL go to 0.
REQ-030 On reset, the refresh counter and digit index SHALL go to 0, and all display registers SHALL go to 0, so the display shows "0" on digit0.
REQ-031 Immediately after reset, an SHALL be the digit0 enable (4'b1110 when ACTIVE_LOW=1) and seg SHALL be the code for 0 (7'h40 when ACTIVE_LOW=1).
REQ-032 rst asserted mid-conversion SHALL abort it: no done pulse, and display registers cleared.
REQ-033 rst SHALL have priority over load in the same cycle.

Verification
REQ-034 Bench: reset, then load value=30 -> done exactly 10 cycles after the load edge; digits ones=0, tens=3, hundreds blank; busy high for 9 cycles.
REQ-035 Bench: value=0, then 9, then 255 -> displays "0", "9" (tens and hundreds blank) and "255" respectively.
REQ-036 Bench: value=105 -> hundreds=1, tens=0 shown (not blanked), ones=5.
REQ-037 Bench: load value=12, then pulse load with value=99 three cycles later -> the 99 is ignored and the result is 12.
REQ-038 Bench: rst at the 4th CONV cycle of value=200 -> no done, busy=0 next cycle, display shows "0".
REQ-039 Bench: REFRESH_DIV=4, observe 20 cycles -> an walks 1110, 1101, 1011, 0111 every 4 cycles, one-hot, with seg=7F (blank, inverted) on digit3.
